// File: rtl/uart_sender_receiver.sv
// Purpose: 8N1 UART transmitter plus independent receiver sharing one clock.
// Latency: TX line goes low 1 cycle after an accepted trigger edge. RX result lands mid-stop-bit, about 3 cycles of sync/detect after the line edge.
// Backpressure: none. A trigger while busy or disabled is dropped. A received byte overwrites readdata.
//
// Ports:
//   sysclk, reset        clock; synchronous active-high reset
//   UART_RX              async serial input, idles high (2-flop synchronized)
//   recv_enable          receiver may accept frames; low aborts a frame in progress
//   recv_finish/readdata 1-cycle pulse and last good byte
//   writedata            byte latched on an accepted trigger edge
//   send_trigger         rising edge requests a transmission
//   send_enable          transmitter may start
//   send_work_state      high while a frame is on the line
//   send_finish          1-cycle pulse after the stop bit
//   UART_TX              serial output, idles high
// Optional: define UART_STOP_CHECK_EN to discard frames whose stop sample is 0.
module uart_sender_receiver #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       recv_enable,
  output logic       recv_finish,
  output logic [7:0] readdata,
  input  logic [7:0] writedata,
  input  logic       send_trigger,
  input  logic       send_enable,
  output logic       send_work_state,
  output logic       send_finish,
  output logic       UART_TX
);

  // One bit is 16 ticks of DIV cycles each. Counters run in raw cycles.
  localparam int DIV_RAW  = CLK_FREQ / (16 * BAUD_RATE);
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int BIT_CYC  = 16 * DIV;
  localparam int HALF_CYC = 8 * DIV;
  localparam int CNT_W    = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // ---------------- transmitter ----------------
  state_e           tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_idx_q;
  logic [7:0]       tx_shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             send_finish_q;
  logic             trig_q;
  logic             trig_edge;
  logic             tx_bit_end;

  assign trig_edge  = send_trigger & ~trig_q;
  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_state_q    <= ST_IDLE;
      tx_cnt_q      <= '0;
      tx_idx_q      <= '0;
      tx_shift_q    <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      send_finish_q <= 1'b0;
      trig_q        <= 1'b0;
    end else begin
      trig_q        <= send_trigger;
      send_finish_q <= 1'b0;
      case (tx_state_q)
        ST_IDLE: begin
          if (trig_edge && send_enable) begin
            tx_state_q <= ST_START;
            tx_shift_q <= writedata;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_START: begin
          if (tx_bit_end) begin
            tx_state_q <= ST_DATA;
            tx_cnt_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              tx_state_q <= ST_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_idx_q   <= tx_idx_q + 3'd1;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (tx_bit_end) begin
            tx_state_q    <= ST_IDLE;
            tx_cnt_q      <= '0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            send_finish_q <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  assign UART_TX         = tx_q;
  assign send_work_state = busy_q;
  assign send_finish     = send_finish_q;

  // ---------------- receiver ----------------
  state_e           rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_idx_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       readdata_q;
  logic             recv_finish_q;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic             rx_bit_end;

  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_state_q    <= ST_IDLE;
      rx_cnt_q      <= '0;
      rx_idx_q      <= '0;
      rx_shift_q    <= '0;
      readdata_q    <= '0;
      recv_finish_q <= 1'b0;
      // Synchronizer resets to the idle level so no false start follows reset.
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
    end else begin
      rx_meta_q     <= UART_RX;
      rx_sync_q     <= rx_meta_q;
      recv_finish_q <= 1'b0;
      if (!recv_enable) begin
        // Disabling drops any partial frame silently.
        rx_state_q <= ST_IDLE;
        rx_cnt_q   <= '0;
        rx_idx_q   <= '0;
      end else begin
        case (rx_state_q)
          ST_IDLE: begin
            if (!rx_sync_q) begin
              rx_state_q <= ST_START;
              rx_cnt_q   <= '0;
            end
          end
          ST_START: begin
            // Re-check at mid start bit; a high line means it was a glitch.
            if (rx_cnt_q == HALF_LAST) begin
              rx_cnt_q   <= '0;
              rx_idx_q   <= '0;
              rx_state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
            end else begin
              rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
          end
          ST_DATA: begin
            if (rx_bit_end) begin
              rx_cnt_q   <= '0;
              rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
              if (rx_idx_q == 3'd7) begin
                rx_state_q <= ST_STOP;
              end else begin
                rx_idx_q <= rx_idx_q + 3'd1;
              end
            end else begin
              rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
          end
          ST_STOP: begin
            if (rx_bit_end) begin
              rx_state_q <= ST_IDLE;
              rx_cnt_q   <= '0;
`ifdef UART_STOP_CHECK_EN
              if (rx_sync_q) begin
                readdata_q    <= rx_shift_q;
                recv_finish_q <= 1'b1;
              end
`else
              readdata_q    <= rx_shift_q;
              recv_finish_q <= 1'b1;
`endif
            end else begin
              rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
          end
          default: rx_state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign readdata    = readdata_q;
  assign recv_finish = recv_finish_q;

endmodule

// File: tb/tb_uart_sender_receiver.sv
module tb_uart_sender_receiver;

  localparam int CLK_FREQ  = 1600000;
  localparam int BAUD_RATE = 100000;
`ifdef UART_STOP_CHECK_EN
  localparam bit STOP_CHK = 1'b1;
`else
  localparam bit STOP_CHK = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       reset;
  logic       rx_line;
  logic       rx_drv;
  logic       loop_en;
  logic       recv_enable;
  logic       recv_finish;
  logic [7:0] readdata;
  logic [7:0] writedata;
  logic       send_trigger;
  logic       send_enable;
  logic       send_work_state;
  logic       send_finish;
  logic       UART_TX;

  int         tests   = 0;
  int         fails   = 0;
  int         fin_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd;

  always #5 sysclk = ~sysclk;

  assign rx_line = loop_en ? UART_TX : rx_drv;

  uart_sender_receiver #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .sysclk         (sysclk),
    .reset          (reset),
    .UART_RX        (rx_line),
    .recv_enable    (recv_enable),
    .recv_finish    (recv_finish),
    .readdata       (readdata),
    .writedata      (writedata),
    .send_trigger   (send_trigger),
    .send_enable    (send_enable),
    .send_work_state(send_work_state),
    .send_finish    (send_finish),
    .UART_TX        (UART_TX)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // Scoreboard: every recv_finish pulse must match the oldest expected byte.
  always @(negedge sysclk) begin
    if (send_finish) fin_cnt++;
    if (recv_finish) begin
      if (exp_q.size() == 0) begin
        check("rx_unexpected_pulse", {24'h0, readdata}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rx_data", {24'h0, readdata}, {24'h0, e});
      end
    end
  end

  // Transmit one frame and check every line level for its full bit time.
  task automatic tx_frame(input logic [7:0] d, input int retrig);
    logic [9:0] bits;
    int fin0, match, work, idle_ok, cyc;
    bits = {1'b1, d, 1'b0};
    fin0 = fin_cnt;
    work = 0;
    writedata = d;
    send_trigger = 1'b1;
    step();
    send_trigger = 1'b0;
    for (int b = 0; b < 10; b++) begin
      match = 0;
      for (int c = 0; c < 16; c++) begin
        cyc = b * 16 + c;
        if (cyc == retrig) send_trigger = 1'b1;
        if (cyc == retrig + 3) send_trigger = 1'b0;
        if (cyc == 30) writedata = ~d;
        if (UART_TX === bits[b]) match++;
        if (send_work_state === 1'b1) work++;
        step();
      end
      check($sformatf("tx_bit%0d_cycles", b), match, 16);
    end
    check("tx_work_cycles", work, 160);
    check("tx_finish_pulse", {31'h0, send_finish}, 1);
    check("tx_done_state", {30'h0, send_work_state, UART_TX}, 32'h1);
    idle_ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (UART_TX === 1'b1 && send_work_state === 1'b0) idle_ok++;
    end
    check("tx_idle_after", idle_ok, 40);
    check("tx_finish_count", fin_cnt - fin0, 1);
    send_trigger = 1'b0;
  endtask

  // Drive one serial frame on the RX line; optionally drop recv_enable mid-frame.
  task automatic rx_frame(input logic [7:0] d, input logic stop_b, input int abort_at,
                          input logic exp_pulse);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    if (exp_pulse) begin
      exp_q.push_back(d);
      last_rd = d;
    end
    for (int i = 0; i < 160; i++) begin
      rx_drv = bits[i / 16];
      if (i == abort_at) recv_enable = 1'b0;
      step();
    end
    rx_drv = 1'b1;
    repeat (30) step();
    recv_enable = 1'b1;
    check("rx_q_empty", exp_q.size(), 0);
    check("rx_hold", {24'h0, readdata}, {24'h0, last_rd});
  endtask

  typedef struct {
    logic [7:0] data;
    int         retrig;
    logic       loopback;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    int         abort_at;
    logic       exp_pulse;
  } rx_vec_t;

  tx_vec_t txv[3];
  rx_vec_t rxv[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin0, idle_ok;

    txv[0] = '{8'hA5, -1, 1'b0};
    txv[1] = '{8'hC3, 40, 1'b0};
    txv[2] = '{8'h3C, -1, 1'b1};

    rxv[0] = '{8'h55, 1'b1, -1, 1'b1};
    rxv[1] = '{8'h00, 1'b1, -1, 1'b1};
    rxv[2] = '{8'hFF, 1'b1, -1, 1'b1};
    rxv[3] = '{8'h81, 1'b0, -1, !STOP_CHK};
    rxv[4] = '{8'h5A, 1'b1, 60, 1'b0};

    reset        = 1'b1;
    rx_drv       = 1'b1;
    loop_en      = 1'b0;
    recv_enable  = 1'b1;
    writedata    = 8'h00;
    send_trigger = 1'b0;
    send_enable  = 1'b1;
    last_rd      = 8'h00;
    repeat (3) step();
    check("rst_tx", {31'h0, UART_TX}, 1);
    check("rst_work", {31'h0, send_work_state}, 0);
    check("rst_send_finish", {31'h0, send_finish}, 0);
    check("rst_recv_finish", {31'h0, recv_finish}, 0);
    check("rst_readdata", {24'h0, readdata}, 0);
    reset = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 3; i++) begin
      loop_en = txv[i].loopback;
      if (txv[i].loopback) begin
        exp_q.push_back(txv[i].data);
        last_rd = txv[i].data;
      end
      tx_frame(txv[i].data, txv[i].retrig);
      check("tx_loop_q_empty", exp_q.size(), 0);
      check("tx_loop_readdata", {24'h0, readdata}, {24'h0, last_rd});
      loop_en = 1'b0;
    end

    for (int i = 0; i < 5; i++) begin
      rx_frame(rxv[i].data, rxv[i].stop_b, rxv[i].abort_at, rxv[i].exp_pulse);
    end

    // Short low glitch must not start a frame.
    rx_drv = 1'b0;
    repeat (4) step();
    rx_drv = 1'b1;
    repeat (40) step();
    check("glitch_q_empty", exp_q.size(), 0);
    check("glitch_readdata", {24'h0, readdata}, {24'h0, last_rd});

    // Reset in the middle of a transmission.
    fin0 = fin_cnt;
    writedata = 8'h0F;
    send_trigger = 1'b1;
    step();
    send_trigger = 1'b0;
    repeat (49) step();
    check("midrst_busy_before", {31'h0, send_work_state}, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_tx", {31'h0, UART_TX}, 1);
    check("midrst_work", {31'h0, send_work_state}, 0);
    check("midrst_finish", {31'h0, send_finish}, 0);
    check("midrst_readdata", {24'h0, readdata}, 0);
    idle_ok = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (UART_TX === 1'b1 && send_work_state === 1'b0) idle_ok++;
    end
    check("midrst_idle", idle_ok, 200);
    check("midrst_no_finish", fin_cnt - fin0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
